// File: rtl/cnu_serial_acc.sv
// Serial min-sum check-node accumulator: folds one v2c message per cycle
// into {sign product, min1 index, edge count, min1, min2} for the current row.
module cnu_serial_acc #(
   parameter int D_WID = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 v2c_vld,
   input  logic                 v2c_sgn,
   input  logic [D_WID-1:0]     v2c_mag,
   input  logic                 v2c_last,
   output logic [2*D_WID+9:0]   cnu_q,
   output logic                 cnu_vld,
   output logic                 busy,
   output logic                 err_ovf
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;

   logic [0:0]       state;
   logic             sgn_q;
   logic [D_WID-1:0] min1_q;
   logic [D_WID-1:0] min2_q;
   logic [4:0]       idx_q;
   logic [5:0]       cnt_q;

   logic             first;
   logic             ovf_edge;
   logic             nx_sgn;
   logic [D_WID-1:0] nx_min1;
   logic [D_WID-1:0] nx_min2;
   logic [4:0]       nx_idx;
   logic [5:0]       nx_cnt;
   logic [3:0]       cnt_fld;

   assign first = (state == S_IDLE);
   // Edge index k equals the count held so far; k >= 32 is an overflow edge
   assign ovf_edge = !first && cnt_q[5];

   always_comb begin
      nx_sgn  = sgn_q;
      nx_min1 = min1_q;
      nx_min2 = min2_q;
      nx_idx  = idx_q;
      nx_cnt  = cnt_q;
      if (first) begin
         nx_sgn  = v2c_sgn;
         nx_min1 = v2c_mag;
         nx_min2 = '1;
         nx_idx  = 5'd0;
         nx_cnt  = 6'd1;
      end else begin
         nx_sgn = sgn_q ^ v2c_sgn;
         nx_cnt = (&cnt_q) ? cnt_q : cnt_q + 6'd1;
         if (!ovf_edge && (v2c_mag < min1_q)) begin
            nx_min2 = min1_q;
            nx_min1 = v2c_mag;
            nx_idx  = cnt_q[4:0];
         end else if (v2c_mag < min2_q) begin
            nx_min2 = v2c_mag;
         end
      end
   end

   assign cnt_fld = (nx_cnt > 6'd15) ? 4'hF : nx_cnt[3:0];
   assign busy    = (state == S_ACC);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         sgn_q   <= 1'b0;
         min1_q  <= '0;
         min2_q  <= '0;
         idx_q   <= 5'd0;
         cnt_q   <= 6'd0;
         cnu_q   <= '0;
         cnu_vld <= 1'b0;
         err_ovf <= 1'b0;
      end else if (clr) begin
         // Partial row is dropped; the last record stays visible
         state   <= S_IDLE;
         cnt_q   <= 6'd0;
         cnu_vld <= 1'b0;
         err_ovf <= 1'b0;
      end else begin
         cnu_vld <= 1'b0;
         if (v2c_vld) begin
            sgn_q  <= nx_sgn;
            min1_q <= nx_min1;
            min2_q <= nx_min2;
            idx_q  <= nx_idx;
            cnt_q  <= nx_cnt;
            if (ovf_edge)
               err_ovf <= 1'b1;
            if (v2c_last) begin
               cnu_q   <= {nx_sgn, nx_idx, cnt_fld, nx_min1, nx_min2};
               cnu_vld <= 1'b1;
               cnt_q   <= 6'd0;
               state   <= S_IDLE;
            end else begin
               state <= S_ACC;
            end
         end
      end
   end

endmodule

// File: tb/tb_cnu_serial_acc.sv
// Bench for cnu_serial_acc: directed rows plus random rows checked
// against a row-level reference model built from queued edges.
module tb_cnu_serial_acc;

   localparam int D  = 8;
   localparam int QW = 2*D+10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clr = 1'b0;
   logic          v2c_vld = 1'b0;
   logic          v2c_sgn = 1'b0;
   logic [D-1:0]  v2c_mag = '0;
   logic          v2c_last = 1'b0;
   logic [QW-1:0] cnu_q;
   logic          cnu_vld;
   logic          busy;
   logic          err_ovf;

   int n_chk = 0;
   int n_err = 0;

   int            row_m[$];
   bit            row_s[$];
   logic [QW-1:0] exp_q = '0;
   bit            exp_vld = 1'b0;
   bit            exp_ovf = 1'b0;

   always #5 clk = ~clk;

   cnu_serial_acc #(.D_WID(D)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .v2c_vld  (v2c_vld),
      .v2c_sgn  (v2c_sgn),
      .v2c_mag  (v2c_mag),
      .v2c_last (v2c_last),
      .cnu_q    (cnu_q),
      .cnu_vld  (cnu_vld),
      .busy     (busy),
      .err_ovf  (err_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Record of the queued row: argmin over the first 32 edges, second
   // smallest of those, then lowered by any later (overflow) edge.
   function automatic logic [QW-1:0] model_rec();
      int n   = row_m.size();
      int lim = (n < 32) ? n : 32;
      int m1, idx, m2, cnt;
      int srt[$];
      bit s = 1'b0;
      foreach (row_s[i]) s ^= row_s[i];
      m1  = row_m[0];
      idx = 0;
      for (int i = 1; i < lim; i++)
         if (row_m[i] < m1) begin
            m1  = row_m[i];
            idx = i;
         end
      for (int i = 0; i < lim; i++) srt.push_back(row_m[i]);
      srt.sort();
      m2 = (lim > 1) ? srt[1] : (1 << D) - 1;
      for (int i = 32; i < n; i++)
         if (row_m[i] < m2) m2 = row_m[i];
      cnt = (n > 15) ? 15 : n;
      return {s, 5'(idx), 4'(cnt), 8'(m1), 8'(m2)};
   endfunction

   task automatic step(input bit vld, input bit s, input int m,
                       input bit last, input bit c);
      v2c_vld  = vld;
      v2c_sgn  = s;
      v2c_mag  = D'(m);
      v2c_last = last;
      clr      = c;
      exp_vld  = 1'b0;
      if (c) begin
         row_m.delete();
         row_s.delete();
         exp_ovf = 1'b0;
      end else if (vld) begin
         row_m.push_back(m);
         row_s.push_back(s);
         if (row_m.size() > 32) exp_ovf = 1'b1;
         if (last) begin
            exp_q   = model_rec();
            exp_vld = 1'b1;
            row_m.delete();
            row_s.delete();
         end
      end
      @(negedge clk);
      v2c_vld  = 1'b0;
      v2c_last = 1'b0;
      clr      = 1'b0;
      check("cnu_vld", cnu_vld, exp_vld);
      check("cnu_q", cnu_q, exp_q);
      check("busy", busy, row_m.size() > 0);
      check("err_ovf", err_ovf, exp_ovf);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic mid_reset();
      #2 reset_n = 1'b0;
      #1;
      check("rst_cnu_q", cnu_q, 0);
      check("rst_cnu_vld", cnu_vld, 0);
      check("rst_busy", busy, 0);
      check("rst_err_ovf", err_ovf, 0);
      row_m.delete();
      row_s.delete();
      exp_q   = '0;
      exp_vld = 1'b0;
      exp_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int len;
      bit aborted;
      repeat (2) @(negedge clk);
      check("reset_cnu_q", cnu_q, 0);
      check("reset_cnu_vld", cnu_vld, 0);
      check("reset_busy", busy, 0);
      check("reset_err_ovf", err_ovf, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Tie with min1 goes to min2
      step(1, 0, 20, 0, 0);
      step(1, 1, 5, 0, 0);
      step(1, 1, 9, 0, 0);
      step(1, 0, 5, 1, 0);
      check("tie_rec", cnu_q, {1'b0, 5'd1, 4'd4, 8'd5, 8'd5});
      idle();

      step(1, 1, 37, 1, 0);
      check("single_rec", cnu_q, {1'b1, 5'd0, 4'd1, 8'd37, 8'd255});
      idle();

      // Back-to-back rows
      step(1, 0, 3, 0, 0);
      step(1, 0, 7, 1, 0);
      check("rowA_rec", cnu_q, {1'b0, 5'd0, 4'd2, 8'd3, 8'd7});
      step(1, 1, 100, 0, 0);
      step(1, 0, 2, 1, 0);
      check("rowB_rec", cnu_q, {1'b1, 5'd1, 4'd2, 8'd2, 8'd100});
      idle();

      for (int i = 0; i < 20; i++) step(1, 0, 200 - i, i == 19, 0);
      check("sat_rec", cnu_q, {1'b0, 5'd19, 4'd15, 8'd181, 8'd182});
      idle();

      // Overflow row: the true minimum arrives at edge 33
      for (int i = 0; i < 34; i++)
         step(1, 1'($urandom), (i == 33) ? 1 : $urandom_range(2, 255),
              i == 33, 0);
      check("ovf_flag", err_ovf, 1);
      check("ovf_min2", cnu_q[7:0], 1);
      check("ovf_min1_not1", cnu_q[15:8] != 8'd1, 1);
      repeat (3) idle();

      step(1, 0, 11, 0, 0);
      step(1, 1, 12, 0, 0);
      step(1, 0, 13, 0, 0);
      step(1, 0, 1, 0, 1);
      check("clr_busy", busy, 0);
      check("clr_ovf", err_ovf, 0);
      step(1, 0, 4, 1, 0);
      check("post_clr_rec", cnu_q, {1'b0, 5'd0, 4'd1, 8'd4, 8'd255});
      idle();

      step(1, 1, 60, 0, 0);
      step(1, 0, 61, 0, 0);
      mid_reset();
      step(1, 1, 9, 0, 0);
      step(1, 0, 3, 1, 0);
      check("post_rst_rec", cnu_q, {1'b1, 5'd1, 4'd2, 8'd3, 8'd9});

      for (int r = 0; r < 60; r++) begin
         len = $urandom_range(1, 40);
         aborted = 1'b0;
         for (int e = 0; e < len && !aborted; e++) begin
            if ($urandom_range(0, 3) == 0)
               step(0, 1'($urandom), $urandom_range(0, 255),
                    1'($urandom), 0);
            if ($urandom_range(0, 59) == 0) begin
               step(1'($urandom), 1'($urandom), $urandom_range(0, 255),
                    1'($urandom), 1);
               aborted = 1'b1;
            end else begin
               step(1, 1'($urandom), $urandom_range(0, 255),
                    e == len - 1, 0);
            end
         end
         if ($urandom_range(0, 7) == 0) step(0, 0, 0, 0, 1);
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cnu_serial_acc.md
Name: cnu_serial_acc

Overview:
- Serial min-sum check-node accumulator for the LDPC decoder.
- Consumes one variable-to-check (v2c) message per cycle for the current parity row.
- At row end, produces the compressed check-node record {sign product, min1 index, edge count, min1, min2}.
- Six instances drive the cnu0_q..cnu5_q record inputs of the check-node record store stage, which packs records two per memory word.

Parameters:
- D_WID, 8, magnitude width of v2c messages and of the min1/min2 fields.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous flush; abandons any partial row
- v2c_vld  input  1  v2c message valid this cycle
- v2c_sgn  input  1  v2c sign (1 = negative)
- v2c_mag  input  D_WID  v2c magnitude, unsigned
- v2c_last  input  1  qualifies v2c_vld; marks the final edge of the row
- cnu_q  output  2*D_WID+10  record, bit layout:
  - [2D+9] sign_prod
  - [2D+8:2D+4] min1_idx
  - [2D+3:2D] edge_cnt
  - [2D-1:D] min1
  - [D-1:0] min2
- cnu_vld  output  1  one-cycle pulse; cnu_q updated this cycle
- busy  output  1  high while a row is partially accumulated
- err_ovf  output  1  sticky; set when a row exceeds 32 edges

Behaviour:
- Reset (reset_n low, asynchronous):
  - cnu_q = 0, cnu_vld = 0, busy = 0, err_ovf = 0.
  - Internal accumulators and the edge counter are cleared; state = IDLE.
- Two states:
  - IDLE: no edges held.
  - ACC: at least one edge held.
  - IDLE -> ACC on v2c_vld & !v2c_last.
  - ACC -> IDLE on v2c_vld & v2c_last, or on clr.
  - busy = (state == ACC).
- First edge of a row (state IDLE, v2c_vld):
  - min1 = mag, min2 = all ones, idx = 0, sgn = v2c_sgn, cnt = 1.
- Subsequent edge k (0-based, state ACC):
  - sgn ^= v2c_sgn.
  - If mag < min1: min2 = min1, min1 = mag, idx = k.
  - Else if mag < min2: min2 = mag.
  - Tie with min1 (mag == min1): goes to min2; idx is unchanged.
- Edge counter is 6 bits internally.
  - edge_cnt field = min(count, 15), saturating.
  - min1_idx field = idx[4:0].
- More than 32 edges in a row:
  - err_ovf is set.
  - Edges beyond the 32nd still update sgn and min2 but never update min1 or idx.
  - err_ovf clears only on reset_n or clr.
- Row completion (v2c_vld & v2c_last):
  - On the next rising edge, cnu_q is loaded with the record including that final edge, and cnu_vld = 1 for exactly one cycle.
  - Latency = 1 cycle from the last accepted edge.
- Single-edge row (v2c_last with state IDLE):
  - Valid.
  - Record has min2 = all ones, idx = 0, cnt = 1.
- Back-to-back rows:
  - A new row's first edge is accepted in the cycle immediately after v2c_last.
  - No bubble is required.
  - cnu_q holds its value until the next completion.
- v2c_vld low:
  - Accumulators hold.
  - Gaps inside a row are allowed, with no timeout.
- clr:
  - Has priority over v2c_vld in the same cycle; that edge is discarded.
  - Returns state to IDLE and clears err_ovf.
  - cnu_q is unchanged.
  - No cnu_vld is produced.
- v2c_last without v2c_vld is ignored.
- reset_n asserted mid-row: all state is lost immediately; no record is emitted.

Test Plan:
- D_WID=8, edges (sgn,mag) = (0,20),(1,5),(1,9),(0,5)+last -> next cycle cnu_vld=1, cnu_q fields sgn=0, idx=1, cnt=4, min1=5, min2=5 (tie); busy low after.
- Single edge (1,37)+last -> cnu_q sgn=1, idx=0, cnt=1, min1=37, min2=255; one-cycle cnu_vld.
- Two rows back-to-back with no idle cycle: row A = (0,3),(0,7)+last, row B = (1,100),(0,2)+last.
  - cnu_vld pulses twice, two cycles apart.
  - Records: A = {0,0,2,3,7}, B = {1,1,2,2,100}.
- 20-edge row, magnitudes 200 down to 181, last mag 181 -> cnt=15 (saturated), idx=19, min1=181, min2=182.
- 34-edge row, minimum mag 1 placed at edge 33 -> err_ovf=1; min1 is not 1 and idx is not 33; min2=1; err_ovf stays high until clr.
- Three edges then clr in the same cycle as a v2c_vld edge -> busy=0, no cnu_vld, cnu_q unchanged. Next row (0,4)+last -> record {0,0,1,4,255}.
- Assert reset_n mid-row -> all outputs 0 immediately (asynchronous); subsequent row accumulates cleanly.
